// File: rtl/control_seq_pkg.sv
`default_nettype none
// ====================================================================
// control_pkg : shared state encoding, clog2 helper and default sizes
// Revision: 1.0
// ====================================================================
package control_pkg;

  localparam int DEF_ADDR_WIDTH   = 5;
  localparam int DEF_TXC_BIT      = 2;
  localparam int DEF_NUM_CHANNELS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/control_seq_if.sv
`default_nettype none
// ====================================================================
// control_seq_if : control/status bundle between sequencer and its user
// Revision: 1.0
// ====================================================================
interface control_seq_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int CHAN_WIDTH = 2
);

  logic                  enable;
  logic                  clear;
  logic                  mode_oneshot;
  logic                  start;
  logic [ADDR_WIDTH-1:0] limit;
  logic [ADDR_WIDTH-1:0] ramadrs;
  logic                  oeenable;
  logic                  outstrobe;
  logic                  txc;
  logic [CHAN_WIDTH-1:0] chan;
  logic                  wrap;
  logic                  busy;
  logic                  done;

  modport master (
    output enable, clear, mode_oneshot, start, limit,
    input  ramadrs, oeenable, outstrobe, txc, chan, wrap, busy, done
  );

  modport slave (
    input  enable, clear, mode_oneshot, start, limit,
    output ramadrs, oeenable, outstrobe, txc, chan, wrap, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/control_seq_adrs.sv
`default_nettype none
// ====================================================================
// control_seq_adrs : wrapping RAM address counter with terminal count
// Revision: 1.0
// ====================================================================
module control_seq_adrs #(
  parameter int ADDR_WIDTH = 5
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  clear_i,
  input  wire logic                  load_i,
  input  wire logic                  advance_i,
  input  wire logic [ADDR_WIDTH-1:0] limit_i,
  output logic      [ADDR_WIDTH-1:0] adrs_o,
  output logic                       last_o,
  output logic                       wrap_o
);

  logic [ADDR_WIDTH-1:0] adrs_q, adrs_d;
  logic [ADDR_WIDTH-1:0] limit_q, limit_d;
  logic                  wrap_q, wrap_d;

  assign last_o = (adrs_q == limit_q);

  // The terminal count is only re-sampled at pass boundaries (start or wrap).
  always_comb begin
    adrs_d  = adrs_q;
    limit_d = limit_q;
    wrap_d  = 1'b0;
    if (clear_i) begin
      adrs_d = '0;
    end else if (load_i) begin
      adrs_d  = '0;
      limit_d = limit_i;
    end else if (advance_i) begin
      if (last_o) begin
        adrs_d  = '0;
        wrap_d  = 1'b1;
        limit_d = limit_i;
      end else begin
        adrs_d = adrs_q + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adrs_q  <= '0;
      limit_q <= limit_i;
      wrap_q  <= 1'b0;
    end else begin
      adrs_q  <= adrs_d;
      limit_q <= limit_d;
      wrap_q  <= wrap_d;
    end
  end

  assign adrs_o = adrs_q;
  assign wrap_o = wrap_q;

endmodule
`default_nettype wire

// File: rtl/control_seq.sv
`default_nettype none
// ====================================================================
// control_seq : RAM address/strobe sequencer with channel rotation and one-shot mode
// Revision: 1.0
// ====================================================================
module control_seq
  import control_pkg::*;
#(
  parameter int  ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int  TXC_BIT      = DEF_TXC_BIT,
  parameter int  NUM_CHANNELS = DEF_NUM_CHANNELS,
  localparam int CHAN_WIDTH   = (clog2(NUM_CHANNELS) > 1) ? clog2(NUM_CHANNELS) : 1
) (
  input wire logic     clock,
  input wire logic     reset,
  control_seq_if.slave bus
);

  state_e                state_q, state_d;
  logic [CHAN_WIDTH-1:0] chan_q, chan_d;
  logic                  oeenable_q, oeenable_d;
  logic                  outstrobe_q, outstrobe_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [ADDR_WIDTH-1:0] adrs;
  logic                  adrs_last;
  logic                  adrs_wrap;
  logic                  run;
  logic                  advance;
  logic                  load;
  logic                  wrap_evt;

  assign run      = (state_q == ST_RUN);
  assign advance  = run && bus.enable && !bus.clear;
  assign load     = (state_q == ST_IDLE) && bus.start && !bus.clear;
  assign wrap_evt = advance && adrs_last;

  control_seq_adrs #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_adrs (
    .clk       (clock),
    .rst       (reset),
    .clear_i   (bus.clear),
    .load_i    (load),
    .advance_i (advance),
    .limit_i   (bus.limit),
    .adrs_o    (adrs),
    .last_o    (adrs_last),
    .wrap_o    (adrs_wrap)
  );

  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    oeenable_d  = run && bus.enable && (adrs[TXC_BIT-1:0] == '0);
    outstrobe_d = run && bus.enable && (&adrs[ADDR_WIDTH-1:TXC_BIT]);
    if (bus.clear) begin
      state_d     = bus.mode_oneshot ? ST_IDLE : ST_RUN;
      chan_d      = '0;
      oeenable_d  = 1'b0;
      outstrobe_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!bus.mode_oneshot || bus.start) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (wrap_evt) begin
            chan_d = (chan_q == CHAN_WIDTH'(NUM_CHANNELS - 1)) ? '0 : chan_q + CHAN_WIDTH'(1);
            if (bus.mode_oneshot) state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    // Status flags are registered copies of the next state so they stay low during reset.
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= bus.mode_oneshot ? ST_IDLE : ST_RUN;
      chan_q      <= '0;
      oeenable_q  <= 1'b0;
      outstrobe_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      oeenable_q  <= oeenable_d;
      outstrobe_q <= outstrobe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.ramadrs   = adrs;
  assign bus.txc       = adrs[TXC_BIT];
  assign bus.wrap      = adrs_wrap;
  assign bus.chan      = chan_q;
  assign bus.oeenable  = oeenable_q;
  assign bus.outstrobe = outstrobe_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_control_seq.sv
`default_nettype none
// ====================================================================
// tb_control_seq : directed self-checking bench for control_seq
// Revision: 1.0
// ====================================================================
module tb_control_seq;

  localparam int AW  = 5;
  localparam int TXC = 2;
  localparam int NCH = 3;
  localparam int CW  = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  int seq2 [16] = '{1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0};

  control_seq_if #(.ADDR_WIDTH(AW), .CHAN_WIDTH(CW)) bus ();

  control_seq #(
    .ADDR_WIDTH   (AW),
    .TXC_BIT      (TXC),
    .NUM_CHANNELS (NCH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {19'd0, bus.ramadrs, bus.oeenable, bus.outstrobe, bus.txc,
            bus.chan, bus.wrap, bus.busy, bus.done};
  endfunction

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bus.enable = 1'b0; bus.clear = 1'b0; bus.mode_oneshot = 1'b0;
    bus.start  = 1'b0; bus.limit = 5'd31;
    #1 reset = 1'b1;
    #2 check_eq("reset_outputs", all_outs(), 32'd0);
    #9 reset = 1'b0;
    bus.enable = 1'b1;

    // Free-run full pass, limit 31
    for (int i = 1; i <= 33; i++) begin
      int prev;
      tick();
      prev = (i - 1) % 32;
      check_eq($sformatf("fr_adrs%0d", i), bus.ramadrs, i % 32);
      check_eq($sformatf("fr_txc%0d", i), bus.txc, ((i % 32) >> 2) & 1);
      check_eq($sformatf("fr_oe%0d", i), bus.oeenable, (prev % 4) == 0);
      check_eq($sformatf("fr_outs%0d", i), bus.outstrobe, prev >= 28);
      check_eq($sformatf("fr_wrap%0d", i), bus.wrap, i == 32);
      check_eq($sformatf("fr_chan%0d", i), bus.chan, (i >= 32) ? 1 : 0);
      check_eq($sformatf("fr_busy%0d", i), bus.busy, 1);
    end

    // New limit only takes effect after the wrap
    bus.limit = 5'd5;
    repeat (31) tick();
    check_eq("lim_wrap_adrs", bus.ramadrs, 0);
    check_eq("lim_wrap_pulse", bus.wrap, 1);
    check_eq("lim_wrap_chan", bus.chan, 2);
    for (int k = 0; k < 16; k++) begin
      tick();
      check_eq($sformatf("lim_adrs%0d", k), bus.ramadrs, seq2[k]);
      check_eq($sformatf("lim_wrap%0d", k), bus.wrap, seq2[k] == 0);
      check_eq($sformatf("lim_chan%0d", k), bus.chan, (k < 5) ? 2 : ((k < 15) ? 0 : 1));
      if (k == 1) bus.limit = 5'd9;
    end

    // Stall at address 6
    repeat (6) tick();
    check_eq("stall_pre_adrs", bus.ramadrs, 6);
    bus.enable = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      check_eq($sformatf("stall_adrs%0d", s), bus.ramadrs, 6);
      check_eq($sformatf("stall_oe%0d", s), bus.oeenable, 0);
      check_eq($sformatf("stall_outs%0d", s), bus.outstrobe, 0);
      check_eq($sformatf("stall_wrap%0d", s), bus.wrap, 0);
      check_eq($sformatf("stall_txc%0d", s), bus.txc, 1);
      check_eq($sformatf("stall_busy%0d", s), bus.busy, 1);
    end
    bus.enable = 1'b1;
    tick(); check_eq("resume_adrs7", bus.ramadrs, 7);
    tick(); check_eq("resume_adrs8", bus.ramadrs, 8);
    tick(); check_eq("resume_adrs9", bus.ramadrs, 9);
    check_eq("resume_oe", bus.oeenable, 1);

    // Free-run clear at address 17, channel 2
    bus.limit = 5'd31;
    tick();
    check_eq("pre_clr_wrap", bus.wrap, 1);
    check_eq("pre_clr_chan", bus.chan, 2);
    repeat (17) tick();
    check_eq("pre_clr_adrs", bus.ramadrs, 17);
    check_eq("pre_clr_oe", bus.oeenable, 1);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check_eq("clr_adrs", bus.ramadrs, 0);
    check_eq("clr_chan", bus.chan, 0);
    check_eq("clr_oe", bus.oeenable, 0);
    check_eq("clr_outs", bus.outstrobe, 0);
    check_eq("clr_busy_freerun", bus.busy, 1);
    tick();
    check_eq("post_clr_adrs", bus.ramadrs, 1);

    // One-shot pass, limit 3
    bus.mode_oneshot = 1'b1;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    bus.limit = 5'd3;
    check_eq("os_clr_adrs", bus.ramadrs, 0);
    check_eq("os_clr_busy", bus.busy, 0);
    tick();
    check_eq("os_idle_adrs", bus.ramadrs, 0);
    check_eq("os_idle_busy", bus.busy, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_eq("os_start_busy", bus.busy, 1);
    check_eq("os_start_adrs", bus.ramadrs, 0);
    check_eq("os_start_done", bus.done, 0);
    tick(); check_eq("os_adrs1", bus.ramadrs, 1); check_eq("os_busy1", bus.busy, 1);
    bus.start = 1'b1;
    tick(); check_eq("os_adrs2", bus.ramadrs, 2); check_eq("os_busy2", bus.busy, 1);
    bus.start = 1'b0;
    tick(); check_eq("os_adrs3", bus.ramadrs, 3); check_eq("os_busy3", bus.busy, 1);
    tick();
    check_eq("os_end_adrs", bus.ramadrs, 0);
    check_eq("os_end_wrap", bus.wrap, 1);
    check_eq("os_end_busy", bus.busy, 0);
    check_eq("os_end_done", bus.done, 1);
    check_eq("os_end_chan", bus.chan, 1);
    tick();
    check_eq("os_after_done", bus.done, 0);
    check_eq("os_after_busy", bus.busy, 0);
    check_eq("os_after_wrap", bus.wrap, 0);
    tick();
    check_eq("os_idle2_busy", bus.busy, 0);
    check_eq("os_idle2_adrs", bus.ramadrs, 0);

    // One-shot clear mid-pass: no done pulse
    bus.limit = 5'd31;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (17) tick();
    check_eq("osc_pre_adrs", bus.ramadrs, 17);
    check_eq("osc_pre_chan", bus.chan, 1);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check_eq("osc_adrs", bus.ramadrs, 0);
    check_eq("osc_chan", bus.chan, 0);
    check_eq("osc_busy", bus.busy, 0);
    check_eq("osc_done", bus.done, 0);
    for (int j = 0; j < 2; j++) begin
      tick();
      check_eq($sformatf("osc_done%0d", j), bus.done, 0);
      check_eq($sformatf("osc_busy%0d", j), bus.busy, 0);
    end

    // Asynchronous reset between clock edges
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    check_eq("ar_pre_adrs", bus.ramadrs, 5);
    check_eq("ar_pre_oe", bus.oeenable, 1);
    check_eq("ar_pre_busy", bus.busy, 1);
    #2 reset = 1'b1;
    #1 check_eq("ar_outputs", all_outs(), 32'd0);
    #1 reset = 1'b0;
    tick();
    check_eq("ar_idle_busy", bus.busy, 0);
    check_eq("ar_idle_adrs", bus.ramadrs, 0);
    check_eq("ar_idle_done", bus.done, 0);
    tick();
    check_eq("ar_idle_done2", bus.done, 0);

    // Free-run with limit 0: wrap every cycle, chan 0->1->2->0
    bus.mode_oneshot = 1'b0;
    bus.limit = 5'd0;
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    for (int m = 0; m < 3; m++) begin
      tick();
      check_eq($sformatf("l0_adrs%0d", m), bus.ramadrs, 0);
      check_eq($sformatf("l0_wrap%0d", m), bus.wrap, 1);
      check_eq($sformatf("l0_chan%0d", m), bus.chan, (m + 1) % 3);
      check_eq($sformatf("l0_busy%0d", m), bus.busy, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/control_seq.md
Name: control_seq

Overview:
- Parametrised successor to the existing address/strobe generator for the RAM-based data store.
- Produces a wrapping RAM address with a programmable terminal count, the oeenable and outstrobe strobes, and the transmit clock txc.
- Adds a round-robin channel index, stall/clear controls and a one-shot mode with a start/done handshake.
- Sits between the system clock/reset and the data-store/output stage.

Parameters:
- addr_width, 5, width of ramadrs; must be >= 2.
- txc_bit, 2, address bit driven onto txc and lowest bit of the outstrobe field; must satisfy 1 <= txc_bit < addr_width.
- num_channels, 4, number of channels cycled on each wrap; must be >= 1.
- chan_width, localparam = max(1, clog2(num_channels)).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  advance permission; low stalls the counter.
- clear  in  1  synchronous clear of counter, channel and FSM.
- mode_oneshot  in  1  0 = free-run, 1 = single pass per start.
- start  in  1  one-shot launch; sampled only in IDLE.
- limit  in  addr_width  terminal count (last address of a pass).
- ramadrs  out  addr_width  RAM address.
- oeenable  out  1  data-store output enable strobe.
- outstrobe  out  1  output-data-valid strobe.
- txc  out  1  transmit clock = ramadrs[txc_bit].
- chan  out  chan_width  current channel index.
- wrap  out  1  one-cycle pulse on address wrap.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at end of a one-shot pass.

Behaviour:
- Reset (async, reset=1): all outputs 0. FSM = IDLE if mode_oneshot=1, RUN otherwise. limit_q <= limit.
- Single clock domain. No combinational path from inputs to outputs except through txc = ramadrs[txc_bit]; every other output is registered.
- FSM states:
  - IDLE: counter held at 0. start=1 -> RUN, ramadrs=0, limit_q <= limit. If mode_oneshot=0 -> RUN unconditionally.
  - RUN: advance = enable. On advance:
    - ramadrs != limit_q: ramadrs <= ramadrs+1.
    - ramadrs == limit_q: ramadrs <= 0, wrap <= 1, chan <= (chan == num_channels-1) ? 0 : chan+1, limit_q <= limit. If mode_oneshot=1 -> DONE.
  - DONE: done=1 for exactly one cycle, busy=0 -> IDLE.
- busy = (state == RUN).
- mode_oneshot is sampled at every state decision. Clearing it while in IDLE enters RUN on the next edge.
- Priority, highest first: reset > clear > start > enable.
- clear=1: ramadrs, chan, wrap, done, oeenable, outstrobe <= 0. State -> IDLE (one-shot) or RUN (free-run).
- limit:
  - Sampled only at reset, on start, and on wrap; mid-pass changes are ignored until the next wrap.
  - limit=0: ramadrs stays 0 and wrap pulses on every advancing cycle.
  - limit >= 2^addr_width-1: natural wrap from all-ones to 0.
- oeenable <= busy && enable && (ramadrs[txc_bit-1:0] == 0). This is one cycle of latency from the address.
- outstrobe <= busy && enable && (&ramadrs[addr_width-1:txc_bit]). It is registered (one-cycle latency) and glitch-free.
- Stall (enable=0 in RUN): ramadrs and chan hold; oeenable, outstrobe and wrap deassert the following cycle; txc holds.
- wrap and done never assert for more than one consecutive cycle unless limit=0 in free-run.
- Reset asserted mid-pass: immediate async return to reset values. No done pulse is produced.
- start in RUN or DONE is ignored (no queuing).

Decomposition:
- control_pkg: FSM state enum (IDLE, RUN, DONE), clog2 function, and default parameter constants.
- One natural sub-module, control_seq_adrs: the wrapping counter with limit_q, advance and wrap outputs. The FSM, strobes and channel rotation stay in the top.

Test Plan:
- Free-run, addr_width=5, txc_bit=2, limit=31, enable=1 -> ramadrs steps 0..31, 0. wrap=1 in the cycle ramadrs returns to 0. oeenable is high one cycle after ramadrs=0, 4, 8, ... outstrobe is high one cycle after ramadrs=28..31. chan goes 0->1.
- limit=5, free-run -> ramadrs sequence 0,1,2,3,4,5,0. A limit change to 9 at ramadrs=2 takes effect only after the wrap; the next pass reaches 9.
- One-shot, limit=3, start pulse -> busy for 4 advancing cycles, ramadrs 0..3. done=1 for one cycle, then IDLE with ramadrs=0. A second start while busy is ignored.
- enable low for 3 cycles at ramadrs=6 -> ramadrs holds at 6. oeenable and outstrobe are 0 during the stall. Counting resumes at 7.
- clear at ramadrs=17, chan=2 -> next cycle ramadrs=0, chan=0, strobes 0. In one-shot mode busy=0 and done never asserts.
- Async reset pulse between clock edges mid-pass -> all outputs 0 immediately. num_channels=3 wraps chan 2->0. limit=0 gives wrap on every cycle.
